// File: rtl/note_ctrl_pkg.sv
// Shared types and constants for the note envelope controller.
// Holds the FSM encoding, key codes and the note period table.
package note_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_SUSTAIN,
    ST_RELEASE
  } state_t;

  localparam logic [2:0] KEY_NONE = 3'd0;
  localparam logic [2:0] KEY_A    = 3'd1;
  localparam logic [2:0] KEY_S    = 3'd2;
  localparam logic [2:0] KEY_D    = 3'd3;
  localparam logic [2:0] KEY_F    = 3'd4;
  localparam logic [2:0] KEY_G    = 3'd5;
  localparam logic [2:0] KEY_H    = 3'd6;
  localparam logic [2:0] KEY_J    = 3'd7;

  // Full-period clock counts at 50 MHz, C4..B4
  localparam logic [31:0] PERIOD_TAB [7] = '{
    32'd191113, 32'd170262, 32'd151687,
    32'd143173, 32'd127553, 32'd113636,
    32'd101239
  };

  function automatic logic [31:0] period_of(
    input logic [2:0] k
  );
    logic [31:0] p;
    p = 32'd0;
    if (k != KEY_NONE) p = PERIOD_TAB[k - 3'd1];
    return p;
  endfunction

endpackage

// File: rtl/amp_ramp.sv
// Saturating up/down amplitude register for the envelope.
// Steps only when step_en is high; flags full scale and zero.
module amp_ramp
  import note_ctrl_pkg::*;
#(
  parameter int AMP_W     = 8,
  parameter int UP_STEP   = 4,
  parameter int DOWN_STEP = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             up,
  input  logic             down,
  input  logic             step_en,
  output logic [AMP_W-1:0] amp,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [AMP_W:0] MAXW =
    {1'b0, {AMP_W{1'b1}}};
  localparam logic [AMP_W:0] UPW =
    (AMP_W+1)'(UP_STEP);
  localparam logic [AMP_W:0] DNW =
    (AMP_W+1)'(DOWN_STEP);

  logic [AMP_W:0]   sum;
  logic [AMP_W:0]   dif;
  logic [AMP_W-1:0] amp_up;
  logic [AMP_W-1:0] amp_dn;

  // One guard bit catches overflow and borrow
  always_comb begin
    sum = {1'b0, amp} + UPW;
    dif = {1'b0, amp} - DNW;
    amp_up = (sum > MAXW) ? MAXW[AMP_W-1:0]
                          : sum[AMP_W-1:0];
    amp_dn = dif[AMP_W] ? '0 : dif[AMP_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      amp <= '0;
    end else if (step_en) begin
      if (up)        amp <= amp_up;
      else if (down) amp <= amp_dn;
    end
  end

  assign at_max  = (amp == MAXW[AMP_W-1:0]);
  assign at_zero = (amp == '0);

endmodule

// File: rtl/note_envelope_ctrl.sv
// Key-driven tone sequencer with attack/sustain/release envelope.
// Optional period glide on note changes: NOTE_GLIDE_EN.
module note_envelope_ctrl
  import note_ctrl_pkg::*;
#(
  parameter int PERIOD_W     = 18,
  parameter int AMP_W        = 8,
  parameter int ATTACK_STEP  = 4,
  parameter int RELEASE_STEP = 2,
  parameter int GLIDE_STEP   = 64
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [2:0]          key,
  input  logic                change,
  input  logic                tick,
  output logic [PERIOD_W-1:0] period,
  output logic [AMP_W-1:0]    amp,
  output logic                active,
  output logic                note_on
);

  state_t state;
  state_t state_n;

  logic [2:0]          key_q;
  logic [PERIOD_W-1:0] target;
  logic [PERIOD_W-1:0] tgt_new;
  logic                load;
  logic                start;
  logic                take;
  logic                step_en;
  logic                at_max;
  logic                at_zero;

  assign tgt_new = PERIOD_W'(period_of(key));

  always_ff @(posedge clock) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    start   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (change && key != KEY_NONE) begin
          state_n = ST_ATTACK;
          load    = 1'b1;
          start   = 1'b1;
        end
      end
      ST_ATTACK, ST_SUSTAIN: begin
        if (state == ST_ATTACK && at_max)
          state_n = ST_SUSTAIN;
        if (change) begin
          if (key == KEY_NONE)
            state_n = ST_RELEASE;
          else if (key != key_q)
            load = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (change && key != KEY_NONE) begin
          state_n = ST_ATTACK;
          load    = 1'b1;
          start   = 1'b1;
        end else if (at_zero) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // A taken transition swallows a coincident tick
  assign take    = (state_n != state) || start;
  assign step_en = tick && !take;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      key_q   <= KEY_NONE;
      target  <= '0;
      note_on <= 1'b0;
    end else begin
      note_on <= start;
      if (load) begin
        key_q  <= key;
        target <= tgt_new;
      end
    end
  end

`ifdef NOTE_GLIDE_EN
  localparam logic [PERIOD_W-1:0] GSTEP =
    PERIOD_W'(GLIDE_STEP);

  logic [PERIOD_W-1:0] p_next;

  always_comb begin
    p_next = period;
    if (period < target) begin
      if (target - period > GSTEP)
        p_next = period + GSTEP;
      else
        p_next = target;
    end else if (period > target) begin
      if (period - target > GSTEP)
        p_next = period - GSTEP;
      else
        p_next = target;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn)
      period <= '0;
    else if (load && state == ST_IDLE)
      period <= tgt_new;
    else if (tick)
      period <= p_next;
  end
`else
  always_ff @(posedge clock) begin
    if (!resetn)   period <= '0;
    else if (load) period <= tgt_new;
  end
`endif

  amp_ramp #(
    .AMP_W     (AMP_W),
    .UP_STEP   (ATTACK_STEP),
    .DOWN_STEP (RELEASE_STEP)
  ) u_ramp (
    .clock   (clock),
    .resetn  (resetn),
    .up      (state == ST_ATTACK),
    .down    (state == ST_RELEASE),
    .step_en (step_en),
    .amp     (amp),
    .at_max  (at_max),
    .at_zero (at_zero)
  );

  assign active = (state != ST_IDLE);

endmodule

// File: tb/tb_note_envelope_ctrl.sv
// Directed bench for note_envelope_ctrl (default build).
// Inputs change and outputs are sampled on the falling edge.
module tb_note_envelope_ctrl;
  import note_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  key = 3'd0;
  logic        change = 1'b0;
  logic        tick = 1'b0;
  logic [17:0] period;
  logic [7:0]  amp;
  logic        active;
  logic        note_on;

  int n_run = 0;
  int n_fail = 0;

  always #10 clock = ~clock;

  note_envelope_ctrl dut (
    .clock   (clock),
    .resetn  (resetn),
    .key     (key),
    .change  (change),
    .tick    (tick),
    .period  (period),
    .amp     (amp),
    .active  (active),
    .note_on (note_on)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic press(input logic [2:0] k);
    key = k;
    change = 1'b1;
    @(negedge clock);
    change = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clock);
      tick = 1'b0;
    end
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_amp", 32'(amp), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_note_on", 32'(note_on), 0);
    resetn = 1'b1;
    cyc();

    press(3'd0);
    chk("idle_key0_active", 32'(active), 0);
    chk("idle_key0_note_on", 32'(note_on), 0);

    press(3'd3);
    chk("start_note_on", 32'(note_on), 1);
    chk("start_period", 32'(period), 151687);
    chk("start_active", 32'(active), 1);
    cyc();
    chk("start_pulse_once", 32'(note_on), 0);
    ticks(63);
    chk("attack_t63", 32'(amp), 252);
    ticks(1);
    chk("attack_t64", 32'(amp), 255);
    cyc();
    chk("sustain_state", 32'(dut.state), 32'(ST_SUSTAIN));

    press(3'd0);
    chk("rel_note_on", 32'(note_on), 0);
    chk("rel_period_kept", 32'(period), 151687);
    ticks(127);
    chk("rel_t127", 32'(amp), 1);
    ticks(1);
    chk("rel_t128", 32'(amp), 0);
    cyc(); cyc();
    chk("rel_idle_active", 32'(active), 0);
    chk("idle_period_held", 32'(period), 151687);

    press(3'd1);
    ticks(25);
    chk("ramp_to_100", 32'(amp), 100);
    press(3'd0);
    chk("rel_at_100", 32'(amp), 100);
    press(3'd5);
    chk("retrig_note_on", 32'(note_on), 1);
    chk("retrig_period", 32'(period), 127553);
    chk("retrig_amp_kept", 32'(amp), 100);
    ticks(1);
    chk("retrig_ramp", 32'(amp), 104);
    ticks(38);
    cyc();
    chk("retrig_sustain", 32'(amp), 255);

    press(3'd1);
`ifndef NOTE_GLIDE_EN
    chk("legato_k1_period", 32'(period), 191113);
`endif
    cyc();
    press(3'd6);
    chk("legato_note_on", 32'(note_on), 0);
`ifndef NOTE_GLIDE_EN
    chk("legato_period", 32'(period), 113636);
`endif
    chk("legato_amp", 32'(amp), 255);
    chk("legato_state", 32'(dut.state), 32'(ST_SUSTAIN));
    press(3'd6);
    chk("same_key_note_on", 32'(note_on), 0);
    chk("same_key_state", 32'(dut.state), 32'(ST_SUSTAIN));

    press(3'd0);
    ticks(2);
    chk("rel_251", 32'(amp), 251);
    press(3'd2);
    chk("retrig2_state", 32'(dut.state), 32'(ST_ATTACK));
    key = 3'd0;
    change = 1'b1;
    tick = 1'b1;
    cyc();
    change = 1'b0;
    tick = 1'b0;
    chk("coincide_state", 32'(dut.state), 32'(ST_RELEASE));
    chk("coincide_amp", 32'(amp), 251);

    press(3'd4);
    chk("pre_rst_active", 32'(active), 1);
    ticks(1);
    resetn = 1'b0;
    cyc();
    chk("midrst_amp", 32'(amp), 0);
    chk("midrst_period", 32'(period), 0);
    chk("midrst_active", 32'(active), 0);
    chk("midrst_note_on", 32'(note_on), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/note_envelope_ctrl.md
# note_envelope_ctrl

Controller that sequences the tone datapath from decoded keyboard notes. Consumes the 3-bit note code and one-cycle `change` pulse from the PS/2 key decoder. Drives a tone generator with a period word and an 8-bit amplitude. Runs an attack/sustain/release envelope stepped by a sample-rate tick.

## Interface
Parameters:
- `PERIOD_W`, default 18: width of the tone period word, in clock cycles per full waveform period.
- `AMP_W`, default 8: amplitude width; full scale is AMP_MAX = 2^AMP_W-1.
- `ATTACK_STEP`, default 4: amplitude increment per tick in ATTACK.
- `RELEASE_STEP`, default 2: amplitude decrement per tick in RELEASE.
- `GLIDE_STEP`, default 64: period slew per tick; used only with the glide feature.

Ports:
- `clock`, in, 1: system clock, 50 MHz.
- `resetn`, in, 1: synchronous, active-low reset.
- `key`, in, 3: note code. 0 = no key; 1..7 = A,S,D,F,G,H,J, mapped to C4..B4.
- `change`, in, 1: one-cycle pulse; `key` is valid and stable on this cycle.
- `tick`, in, 1: one-cycle sample-rate strobe.
- `period`, out, PERIOD_W: period word to the tone generator.
- `amp`, out, AMP_W: current envelope amplitude.
- `active`, out, 1: high whenever the state is not IDLE.
- `note_on`, out, 1: one-cycle pulse when a note starts or is retriggered.

## Operation
- FSM states are IDLE, ATTACK, SUSTAIN, RELEASE.
- Reset values: state=IDLE, `period`=0, `amp`=0, `active`=0, `note_on`=0, latched key=0.
- IDLE:
  - `change` with key≠0: latch key, load the target period, go to ATTACK, pulse `note_on`.
  - `change` with key=0: ignored.
- ATTACK:
  - On each tick: amp = min(amp+ATTACK_STEP, AMP_MAX).
  - When amp reaches AMP_MAX, go to SUSTAIN.
- SUSTAIN: amp is held at AMP_MAX.
- ATTACK or SUSTAIN, `change` with key=0: go to RELEASE. The latched key and period are kept.
- ATTACK or SUSTAIN, `change` with a different nonzero key:
  - Legato: update the latched key and target period.
  - State is unchanged and there is no `note_on` pulse.
- ATTACK or SUSTAIN, `change` with the same key as latched: no effect.
- RELEASE:
  - On each tick: amp = max(amp-RELEASE_STEP, 0).
  - When amp reaches 0, go to IDLE.
  - `period` holds its value in IDLE.
- RELEASE, `change` with key≠0:
  - Retrigger: latch key, load period, go to ATTACK, pulse `note_on`.
  - The ramp continues from the current amp; amp is not reset to 0.
- Saturation arithmetic is computed at AMP_W+1 bits, then clamped. There is no wrap-around.
- Period table, full period at 50 MHz: C4 191113, D4 170262, E4 151687, F4 143173, G4 127553, A4 113636, B4 101239.

## Timing
- `change` at cycle N:
  - state, latched key, target period and `note_on` are registered at N+1.
  - In immediate mode, `period` is also valid at N+1.
- `amp` updates only on the cycle after a tick.
- `change` and `tick` in the same cycle: the state transition wins. That tick's amp step is dropped.
- A tick on the cycle amp saturates does not carry over into the next state.
- `note_on` is never high for two consecutive cycles.
- Reset asserted mid-note: all outputs are at their reset values on the next edge, with no release ramp.

## Configuration
- Macro `NOTE_GLIDE_EN`.
- Defined:
  - A note change during ATTACK, SUSTAIN or RELEASE slews `period` toward the target by GLIDE_STEP per tick, clamped exactly at the target.
  - A note start from IDLE loads `period` immediately.
- Undefined: `period` always equals the target period one cycle after `change`. GLIDE_STEP is unused.

## Structure
- Shared package `note_ctrl_pkg` contains:
  - the state encoding,
  - the 7-entry period table constant,
  - key code constants (0 = none, 1..7).
- Sub-module `amp_ramp`:
  - Inputs: `up`, `down`, `step_en`.
  - Performs saturating AMP_W up/down steps.
  - Reports `at_max` and `at_zero` to the FSM.

## Test plan
- Reset, then key=3 with change, then 64 ticks:
  - `note_on` pulses once, and `period` = 151687 the next cycle.
  - amp = 252 after tick 63 and 255 after tick 64.
  - State goes to SUSTAIN.
- From SUSTAIN, key=0 with change, then 128 ticks:
  - amp = 1 after tick 127.
  - amp = 0 and `active` = 0 after tick 128.
- RELEASE at amp=100, key=5 with change:
  - `note_on` pulses and `period` = 127553.
  - amp ramps from 100 to 104 on the next tick.
- SUSTAIN on key 1, change to key 6:
  - `period` = 113636, with no `note_on` and no amp change.
  - With `NOTE_GLIDE_EN` defined, `period` decreases by 64 per tick and stops exactly at 113636.
- `change` and `tick` on the same cycle in ATTACK:
  - The transition is taken and amp is unchanged that cycle.
- `resetn` low during ATTACK:
  - The next cycle has `amp` = 0, `period` = 0, `active` = 0.
